// File: rtl/flop_pipe_if.sv
// Handshake bundle for flop_pipe: producer side (d/d_valid/d_ready), consumer
// side (q/q_valid/q_ready) and the occupancy count.
interface flop_pipe_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] d;
  logic             d_valid;
  logic             d_ready;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic             q_ready;
  logic [CW-1:0]    count;

  // A word crosses either end only in a cycle where valid && ready are both 1.
  // valid never depends on ready; ready may depend combinationally on the far end.
  modport master (output d, d_valid, q_ready, input d_ready, q, q_valid, count);
  modport slave  (input d, d_valid, q_ready, output d_ready, q, q_valid, count);
endinterface

// File: rtl/flop_pipe.sv
// Elastic register pipeline: DEPTH stages of WIDTH-bit flops with per-stage valid,
// bubble collapsing and occupancy count. Define FLOP_PIPE_CLR_EN for the clr flush port.
module flop_pipe #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic       c,
  input  logic       r,
`ifdef FLOP_PIPE_CLR_EN
  input  logic       clr,
`endif
  flop_pipe_if.slave p
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] ld;
  logic [CW-1:0]    cnt;
  logic             flush;

`ifdef FLOP_PIPE_CLR_EN
  assign flush = clr;
`else
  assign flush = 1'b0;
`endif

  // Stage k may load when some stage from k to the output is empty (a bubble
  // downstream will be absorbed) or the consumer is taking the last word.
  always_comb begin
    logic tail_full;
    tail_full = 1'b1;
    ld        = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      tail_full = tail_full & v[k];
      ld[k]     = !tail_full || p.q_ready;
    end
  end

  always_ff @(posedge c or posedge r) begin
    if (r) begin
      v <= '0;
      for (int k = 0; k < DEPTH; k++) data[k] <= '0;
    end else if (flush) begin
      v <= '0;
    end else begin
      if (ld[0]) begin
        v[0] <= p.d_valid;
        if (p.d_valid) data[0] <= p.d;
      end
      // A bubble moving in clears the valid bit but leaves the data register alone.
      for (int k = 1; k < DEPTH; k++) begin
        if (ld[k]) begin
          v[k] <= v[k-1];
          if (v[k-1]) data[k] <= data[k-1];
        end
      end
    end
  end

  always_comb begin
    cnt = '0;
    for (int k = 0; k < DEPTH; k++) cnt = cnt + CW'(v[k]);
  end

  assign p.d_ready = ld[0] & !flush;
  assign p.q       = data[DEPTH-1];
  assign p.q_valid = v[DEPTH-1] & !flush;
  assign p.count   = cnt;
endmodule
